// File: rtl/cdc_read_bridge.sv
// Single-outstanding read bridge from the master clock domain to a slave-domain responder.
// Each direction crosses as a toggle through a synchronizer; the address and data stay held.
module cdc_read_bridge #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CDC_REG_AMOUNT = 2
) (
  input  logic              rst_m_i,
  input  logic              clk_m_i,
  input  logic              rst_s_i,
  input  logic              clk_s_i,
  input  logic              m_rd_req_i,
  input  logic [ADDR_W-1:0] m_rd_addr_i,
  output logic              m_busy_o,
  output logic              m_rd_valid_o,
  output logic [DATA_W-1:0] m_rd_data_o,
  output logic              s_rd_req_o,
  output logic [ADDR_W-1:0] s_rd_addr_o,
  input  logic              s_rd_valid_i,
  input  logic [DATA_W-1:0] s_rd_data_i
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]          state_q;
  logic                req_tgl_q;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic [CDC_REG_AMOUNT-1:0] ack_sync_q;
  logic                ack_edge_q;
  logic                ack_seen;
  logic                m_rd_valid_q;
  logic [DATA_W-1:0]   m_rd_data_q;

  logic [CDC_REG_AMOUNT-1:0] req_sync_q;
  logic                req_edge_q;
  logic                req_seen;
  logic                s_rd_req_q;
  logic [ADDR_W-1:0]   s_rd_addr_q;
  logic [DATA_W-1:0]   data_hold_q;
  logic                ack_tgl_q;

  always_comb begin
    ack_seen = ack_sync_q[CDC_REG_AMOUNT-1] ^ ack_edge_q;
    req_seen = req_sync_q[CDC_REG_AMOUNT-1] ^ req_edge_q;
  end

  // Master domain: request launch, ack synchronizer and response delivery.
  always_ff @(posedge clk_m_i or posedge rst_m_i) begin
    if (rst_m_i) begin
      state_q      <= StIdle;
      req_tgl_q    <= 1'b0;
      addr_hold_q  <= '0;
      ack_sync_q   <= '0;
      ack_edge_q   <= 1'b0;
      m_rd_valid_q <= 1'b0;
      m_rd_data_q  <= '0;
    end else begin
      ack_sync_q   <= {ack_sync_q[CDC_REG_AMOUNT-2:0], ack_tgl_q};
      ack_edge_q   <= ack_sync_q[CDC_REG_AMOUNT-1];
      m_rd_valid_q <= 1'b0;
      if (state_q == StIdle) begin
        if (m_rd_req_i) begin
          addr_hold_q <= m_rd_addr_i;
          req_tgl_q   <= ~req_tgl_q;
          state_q     <= StWait;
        end
      end else if (ack_seen) begin
        // data_hold_q was written on the same slave edge as the ack toggle, so it is stable here.
        m_rd_data_q  <= data_hold_q;
        m_rd_valid_q <= 1'b1;
        state_q      <= StIdle;
      end
    end
  end

  // Slave domain: request synchronizer, level request and completion capture.
  always_ff @(posedge clk_s_i or posedge rst_s_i) begin
    if (rst_s_i) begin
      req_sync_q  <= '0;
      req_edge_q  <= 1'b0;
      s_rd_req_q  <= 1'b0;
      s_rd_addr_q <= '0;
      data_hold_q <= '0;
      ack_tgl_q   <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[CDC_REG_AMOUNT-2:0], req_tgl_q};
      req_edge_q <= req_sync_q[CDC_REG_AMOUNT-1];
      if (req_seen) begin
        s_rd_req_q  <= 1'b1;
        s_rd_addr_q <= addr_hold_q;
      end else if (s_rd_req_q && s_rd_valid_i) begin
        s_rd_req_q  <= 1'b0;
        data_hold_q <= s_rd_data_i;
        ack_tgl_q   <= ~ack_tgl_q;
      end
    end
  end

  assign m_busy_o     = (state_q == StWait);
  assign m_rd_valid_o = m_rd_valid_q;
  assign m_rd_data_o  = m_rd_data_q;
  assign s_rd_req_o   = s_rd_req_q;
  assign s_rd_addr_o  = s_rd_addr_q;

endmodule

// File: tb/tb_cdc_read_bridge.sv
// Scoreboard bench for cdc_read_bridge: a driver pushes expected reads, a responder models the
// slave CSR bank, and two monitors compare what the DUT presents on each side.
`timescale 1ns / 10ps
module tb_cdc_read_bridge;

  localparam int CDC = 3;

  logic        rst_m_i = 1'b1;
  logic        clk_m_i = 1'b0;
  logic        rst_s_i = 1'b1;
  logic        clk_s_i = 1'b0;
  logic        m_rd_req_i = 1'b0;
  logic [7:0]  m_rd_addr_i = 8'h00;
  logic        m_busy_o;
  logic        m_rd_valid_o;
  logic [31:0] m_rd_data_o;
  logic        s_rd_req_o;
  logic [7:0]  s_rd_addr_o;
  logic        s_rd_valid_i = 1'b0;
  logic [31:0] s_rd_data_i = 32'h0;

  real m_half = 5.0;
  real s_half = 13.5;

  always #(m_half) clk_m_i = ~clk_m_i;
  always #(s_half) clk_s_i = ~clk_s_i;

  cdc_read_bridge #(
    .ADDR_W        (8),
    .DATA_W        (32),
    .CDC_REG_AMOUNT(CDC)
  ) dut (
    .rst_m_i     (rst_m_i),
    .clk_m_i     (clk_m_i),
    .rst_s_i     (rst_s_i),
    .clk_s_i     (clk_s_i),
    .m_rd_req_i  (m_rd_req_i),
    .m_rd_addr_i (m_rd_addr_i),
    .m_busy_o    (m_busy_o),
    .m_rd_valid_o(m_rd_valid_o),
    .m_rd_data_o (m_rd_data_o),
    .s_rd_req_o  (s_rd_req_o),
    .s_rd_addr_o (s_rd_addr_o),
    .s_rd_valid_i(s_rd_valid_i),
    .s_rd_data_i (s_rd_data_i)
  );

  // Reference model: CSR contents plus queues of outstanding expectations.
  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  logic [7:0]  addr_q [$];
  int          delay_q [$];

  int n_chk = 0;
  int n_fail = 0;
  int n_issued = 0;
  int n_sreq = 0;
  int n_resp = 0;
  int m_cyc = 0;
  int s_cyc = 0;
  int m_cyc_at_ack = 0;
  int s_cyc_at_req = 0;
  bit in_req = 0;
  bit spur_en = 0;
  bit prev_valid = 0;
  logic [31:0] last_data = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(posedge clk_m_i) m_cyc <= m_cyc + 1;

  always @(posedge clk_s_i) begin
    s_cyc <= s_cyc + 1;
    if (!rst_s_i && s_rd_req_o && s_rd_valid_i) m_cyc_at_ack = m_cyc;
  end

  // Master monitor.
  always @(negedge clk_m_i) begin
    if (!rst_m_i) begin
      if (m_rd_valid_o) begin
        check("valid_one_cycle", {63'h0, prev_valid}, 64'h0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_m_rd_valid");
        end else begin
          check("rd_data", {32'h0, m_rd_data_o}, {32'h0, exp_q.pop_front()});
          check_range("ack_latency", m_cyc - m_cyc_at_ack, CDC, CDC + 2);
          n_resp++;
        end
        last_data = m_rd_data_o;
      end else begin
        check("rd_data_held", {32'h0, m_rd_data_o}, {32'h0, last_data});
      end
      check("busy", {63'h0, m_busy_o}, {63'h0, exp_q.size() != 0});
      prev_valid = m_rd_valid_o;
    end else begin
      prev_valid = 0;
    end
  end

  // Slave responder and monitor.
  int cnt = 0;
  int cur_delay = 0;
  logic [7:0] cur_addr = 8'h0;
  always @(negedge clk_s_i) begin
    if (rst_s_i) begin
      s_rd_valid_i = 1'b0;
      in_req = 0;
      cnt = 0;
    end else begin
      if (s_rd_req_o && !in_req) begin
        in_req = 1;
        n_sreq++;
        cnt = 0;
        if (addr_q.size() == 0) begin
          fail_now("unexpected_slave_req");
          cur_addr = s_rd_addr_o;
          cur_delay = 0;
        end else begin
          cur_addr = addr_q.pop_front();
          cur_delay = delay_q.pop_front();
          check_range("req_latency", s_cyc - s_cyc_at_req, CDC, CDC + 2);
        end
      end
      if (s_rd_req_o) begin
        check("s_rd_addr", {56'h0, s_rd_addr_o}, {56'h0, cur_addr});
        if (cnt == cur_delay) begin
          s_rd_valid_i = 1'b1;
          s_rd_data_i = mem[s_rd_addr_o];
        end else begin
          s_rd_valid_i = 1'b0;
          s_rd_data_i = $urandom;
        end
        cnt++;
      end else begin
        if (in_req) begin
          check("req_len", cnt, cur_delay + 1);
          in_req = 0;
        end
        if (spur_en && $urandom_range(0, 1) == 1) begin
          s_rd_valid_i = 1'b1;
          s_rd_data_i = 32'h1234;
        end else begin
          s_rd_valid_i = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] addr, input int delay);
    int t = 0;
    do begin
      @(negedge clk_m_i);
      #1;
      t++;
    end while (exp_q.size() != 0 && t < 5000);
    if (t >= 5000) fail_now("timeout_waiting_idle");
    m_rd_req_i = 1'b1;
    m_rd_addr_i = addr;
    @(posedge clk_m_i);
    exp_q.push_back(mem[addr]);
    addr_q.push_back(addr);
    delay_q.push_back(delay);
    s_cyc_at_req = s_cyc;
    n_issued++;
    #1;
    m_rd_req_i = 1'b0;
    m_rd_addr_i = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || in_req) && t < 5000) begin
      @(negedge clk_m_i);
      t++;
    end
    if (t >= 5000) fail_now("timeout_transaction");
    repeat (4) @(negedge clk_m_i);
  endtask

  task automatic do_reset();
    m_rd_req_i = 1'b0;
    rst_m_i = 1'b1;
    rst_s_i = 1'b1;
    repeat (3) @(negedge clk_s_i);
    repeat (3) @(negedge clk_m_i);
    exp_q.delete();
    addr_q.delete();
    delay_q.delete();
    last_data = 32'h0;
    check("rst_busy", {63'h0, m_busy_o}, 64'h0);
    check("rst_valid", {63'h0, m_rd_valid_o}, 64'h0);
    check("rst_data", {32'h0, m_rd_data_o}, 64'h0);
    check("rst_s_req", {63'h0, s_rd_req_o}, 64'h0);
    check("rst_s_addr", {56'h0, s_rd_addr_o}, 64'h0);
    @(negedge clk_m_i);
    rst_m_i = 1'b0;
    rst_s_i = 1'b0;
    repeat (3) @(negedge clk_m_i);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = ~(32'(i));
    mem[8'h5A] = 32'hDEADBEEF;
    mem[8'h22] = 32'hA5A5A5A5;

    do_reset();

    issue(8'h5A, 1);
    wait_idle();

    for (int i = 1; i <= 16; i++) issue(8'(i), 1);
    wait_idle();

    issue(8'h10, 10);
    t = 0;
    while (t < 2000) begin
      @(negedge clk_m_i);
      #1;
      t++;
      if (exp_q.size() != 0) begin
        m_rd_req_i = 1'b1;
        m_rd_addr_i = 8'h77;
      end else begin
        m_rd_req_i = 1'b0;
        break;
      end
    end
    wait_idle();

    spur_en = 1;
    repeat (40) @(negedge clk_s_i);
    issue(8'h33, 0);
    wait_idle();

    for (int i = 0; i < 30; i++) issue(8'($urandom), int'($urandom_range(0, 6)));
    wait_idle();

    spur_en = 0;
    s_half = 1.25;
    repeat (10) @(negedge clk_m_i);
    issue(8'h44, 20);
    wait_idle();
    for (int i = 0; i < 10; i++) issue(8'($urandom), int'($urandom_range(0, 25)));
    wait_idle();

    check("slave_req_count", n_sreq, n_issued);
    check("response_count", n_resp, n_issued);

    issue(8'h66, 400);
    t = 0;
    while (!s_rd_req_o && t < 500) begin
      @(negedge clk_m_i);
      t++;
    end
    if (t >= 500) fail_now("timeout_slave_req");
    repeat (5) @(negedge clk_m_i);
    do_reset();
    n_issued = 0;
    n_sreq = 0;
    n_resp = 0;

    issue(8'h22, 1);
    wait_idle();
    repeat (50) @(negedge clk_m_i);
    check("post_reset_responses", n_resp, 1);
    check("post_reset_slave_reqs", n_sreq, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
